urna_param: RTL and testbench

- Parametrised successor to the fixed 4-candidate electronic ballot box.
- Collects a NUM_DIG-digit BCD candidate code one digit per Valid strobe, then confirms on Finish.
- Tallies votes into NUM_CAND candidate counters plus Nulo (invalid) and Branco (blank) counters.
- Adds cancel/correction, digit validation, saturating counters with a sticky overflow flag, and an election-close lock.

---
 rtl/urna_pkg.sv | 30 +++
 rtl/urna_sat_counter.sv | 37 +++
 rtl/urna_param.sv | 213 +++++++++++++++++++++
 tb/tb_urna_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/urna_pkg.sv
// urna_pkg
//   Shared definitions for the parametrised ballot box:
//   - state_t : entry/commit/lock state of the controller
//   - vclass_t: class of the vote latched when Finish is seen
//   - BCD_MAX : largest legal BCD digit
//   - code_off: bit offset of candidate idx inside the packed CODES vector
package urna_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    FULL    = 3'd2,
    COMMIT  = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    VC_BLANK = 2'd0,
    VC_NULL  = 2'd1,
    VC_CAND  = 2'd2
  } vclass_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Each candidate code is num_dig BCD nibbles wide; candidate idx starts here.
  function automatic int code_off(input int idx, input int num_dig);
    return idx * num_dig * 4;
  endfunction

endpackage

// File: rtl/urna_sat_counter.sv
// urna_sat_counter
//   Saturating up-counter used for every tally of the ballot box.
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - asynchronous active-low reset, clears the count
//     inc      - increment request for this cycle
//     clear    - synchronous clear
//     count    - current tally (CNT_W bits)
//     sat_flag - high while an increment is requested with the count at its maximum
module urna_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             sat_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // An increment that cannot be honoured is what the top turns into Overflow.
  assign sat_flag = inc && (count == CNT_MAX);

  // The count sticks at its maximum instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/urna_param.sv
// urna_param
//   Parametrised electronic ballot box. A NUM_DIG-digit BCD candidate code is
//   entered one digit per Valid strobe and confirmed with Finish; the vote is
//   tallied for the matching candidate, as null (incomplete or unknown code)
//   or as blank (no digits). Cancel discards the digits entered so far and
//   Close locks the box while high.
//   Ports:
//     Clock, Reset_n         - clock and asynchronous active-low reset
//     Digit                  - BCD digit, taken on a Valid rising edge
//     Valid, Finish, Cancel  - level inputs, rising-edge detected here
//     Close                  - election closed while high
//     Counts                 - candidate tallies, candidate i at slice i
//     Nulo, Branco           - null and blank tallies
//     Ndig                   - number of digits currently buffered
//     Status                 - 1 when ready for input
//     Vote_done              - high for the single COMMIT cycle
//     Err                    - one-cycle pulse after a rejected digit
//     Overflow               - sticky, set by any saturating increment
module urna_param
  import urna_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int NUM_DIG  = 4,
  parameter int CNT_W    = 8,
  parameter logic [NUM_CAND*NUM_DIG*4-1:0] CODES =
    {16'h3504, 16'h3472, 16'h3485, 16'h3494}
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [3:0]                Digit,
  input  logic                      Valid,
  input  logic                      Finish,
  input  logic                      Cancel,
  input  logic                      Close,
  output logic [NUM_CAND*CNT_W-1:0] Counts,
  output logic [CNT_W-1:0]          Nulo,
  output logic [CNT_W-1:0]          Branco,
  output logic [3:0]                Ndig,
  output logic                      Status,
  output logic                      Vote_done,
  output logic                      Err,
  output logic                      Overflow
);

  localparam int CODE_W = NUM_DIG * 4;
  localparam int NUM_CNT = NUM_CAND + 2;
  localparam int IDX_NULO = NUM_CAND;
  localparam int IDX_BRANCO = NUM_CAND + 1;

  state_t              state;
  vclass_t             vclass;
  logic [3:0]          vcand;
  logic [CODE_W-1:0]   dig_buf;
  logic                valid_q, finish_q, cancel_q;
  logic                valid_ev, finish_ev, cancel_ev;
  logic                match_hit;
  logic [3:0]          match_idx;
  logic [NUM_CNT-1:0]  inc;
  logic [NUM_CNT-1:0]  sat;
  logic [CNT_W-1:0]    cnt_val [NUM_CNT];

  // The edge registers follow their inputs every cycle, whatever the state,
  // so a level held through COMMIT or LOCKED never fires late.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q  <= 1'b0;
      finish_q <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      valid_q  <= Valid;
      finish_q <= Finish;
      cancel_q <= Cancel;
    end
  end

  assign valid_ev  = Valid  && !valid_q;
  assign finish_ev = Finish && !finish_q;
  assign cancel_ev = Cancel && !cancel_q;

  // Look the buffer up in the code table; scanning downwards lets the lowest
  // index win when two candidates share a code.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (dig_buf == CODES[code_off(i, NUM_DIG) +: CODE_W]) begin
        match_hit = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  // Controller. Close dominates every entry state; within one cycle Cancel
  // beats Finish beats Valid and the losers are dropped. COMMIT always lasts
  // one cycle, and if Close is already high it hands straight over to LOCKED.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      dig_buf   <= '0;
      Ndig      <= '0;
      Status    <= 1'b1;
      Vote_done <= 1'b0;
      Err       <= 1'b0;
      vclass    <= VC_BLANK;
      vcand     <= '0;
    end else begin
      Vote_done <= 1'b0;
      Err       <= 1'b0;
      case (state)
        COMMIT: begin
          dig_buf <= '0;
          Ndig    <= '0;
          if (Close) begin
            state  <= LOCKED;
            Status <= 1'b0;
          end else begin
            state  <= IDLE;
            Status <= 1'b1;
          end
        end
        LOCKED: begin
          if (!Close) begin
            state  <= IDLE;
            Status <= 1'b1;
          end
        end
        default: begin
          if (Close) begin
            state   <= LOCKED;
            Status  <= 1'b0;
            dig_buf <= '0;
            Ndig    <= '0;
          end else if (cancel_ev) begin
            state   <= IDLE;
            dig_buf <= '0;
            Ndig    <= '0;
          end else if (finish_ev) begin
            state     <= COMMIT;
            Status    <= 1'b0;
            Vote_done <= 1'b1;
            vcand     <= match_idx;
            if (state == IDLE) begin
              vclass <= VC_BLANK;
            end else if (state == FULL && match_hit) begin
              vclass <= VC_CAND;
            end else begin
              vclass <= VC_NULL;
            end
          end else if (valid_ev && state != FULL) begin
            if (Digit > BCD_MAX) begin
              Err <= 1'b1;
            end else begin
              dig_buf <= CODE_W'({dig_buf, Digit});
              Ndig    <= Ndig + 4'd1;
              state   <= (Ndig == 4'(NUM_DIG - 1)) ? FULL : COLLECT;
            end
          end
        end
      endcase
    end
  end

  // The latched class selects exactly one counter while in COMMIT, so the
  // tally moves on the edge that leaves COMMIT.
  always_comb begin
    inc = '0;
    if (state == COMMIT) begin
      case (vclass)
        VC_CAND: begin
          for (int i = 0; i < NUM_CAND; i++) begin
            if (vcand == 4'(i)) begin
              inc[i] = 1'b1;
            end
          end
        end
        VC_NULL:  inc[IDX_NULO]   = 1'b1;
        default:  inc[IDX_BRANCO] = 1'b1;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    urna_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .inc      (inc[g]),
      .clear    (1'b0),
      .count    (cnt_val[g]),
      .sat_flag (sat[g])
    );
  end

  // Tally outputs are a registered copy of the counters, so a vote becomes
  // visible one edge after the counter itself moves.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Counts   <= '0;
      Nulo     <= '0;
      Branco   <= '0;
      Overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        Counts[i*CNT_W +: CNT_W] <= cnt_val[i];
      end
      Nulo     <= cnt_val[IDX_NULO];
      Branco   <= cnt_val[IDX_BRANCO];
      Overflow <= Overflow | (|sat);
    end
  end

endmodule

// File: tb/tb_urna_param.sv
// tb_urna_param
//   Drives two ballot boxes (8-bit and 2-bit tallies) with the same votes and
//   compares them against a vote-level model: a queue of entered digits, a
//   locked flag and an unbounded tally per counter, saturated on comparison.
module tb_urna_param;

  localparam int NC = 4;
  localparam int ND = 4;
  localparam logic [63:0] CODES = {16'h3504, 16'h3472, 16'h3485, 16'h3494};

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   digit;
  logic         valid, finish, cancel, close;

  logic [NC*8-1:0] counts_a;
  logic [7:0]      nulo_a, branco_a;
  logic [3:0]      ndig_a;
  logic            status_a, vote_done_a, err_a, overflow_a;

  logic [NC*2-1:0] counts_b;
  logic [1:0]      nulo_b, branco_b;
  logic [3:0]      ndig_b;
  logic            status_b, vote_done_b, err_b, overflow_b;

  int errors = 0;
  int checks = 0;

  int         tally [NC+2];
  logic [3:0] entered [$];
  bit         locked = 1'b0;
  logic [15:0] cand_code [NC] = '{16'h3494, 16'h3485, 16'h3472, 16'h3504};

  always #5 clock = ~clock;

  urna_param #(.NUM_CAND(NC), .NUM_DIG(ND), .CNT_W(8), .CODES(CODES)) u_dut_a (
    .Clock(clock), .Reset_n(reset_n), .Digit(digit), .Valid(valid),
    .Finish(finish), .Cancel(cancel), .Close(close),
    .Counts(counts_a), .Nulo(nulo_a), .Branco(branco_a), .Ndig(ndig_a),
    .Status(status_a), .Vote_done(vote_done_a), .Err(err_a), .Overflow(overflow_a)
  );

  urna_param #(.NUM_CAND(NC), .NUM_DIG(ND), .CNT_W(2), .CODES(CODES)) u_dut_b (
    .Clock(clock), .Reset_n(reset_n), .Digit(digit), .Valid(valid),
    .Finish(finish), .Cancel(cancel), .Close(close),
    .Counts(counts_b), .Nulo(nulo_b), .Branco(branco_b), .Ndig(ndig_b),
    .Status(status_b), .Vote_done(vote_done_b), .Err(err_b), .Overflow(overflow_b)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit anyOver(input int mx);
    for (int i = 0; i < NC + 2; i++) if (tally[i] > mx) return 1'b1;
    return 1'b0;
  endfunction

  // Which tally a Finish lands in: NC = null, NC+1 = blank.
  function automatic int voteIndex();
    int code;
    if (entered.size() == 0) return NC + 1;
    if (entered.size() < ND) return NC;
    code = 0;
    foreach (entered[k]) code = code * 16 + int'(entered[k]);
    for (int i = 0; i < NC; i++) if (code == int'(cand_code[i])) return i;
    return NC;
  endfunction

  task automatic checkTallies(input string tag);
    for (int i = 0; i < NC; i++) begin
      checkOutput($sformatf("%s cnt%0d_a", tag, i), 32'(counts_a[i*8 +: 8]), satv(tally[i], 255));
      checkOutput($sformatf("%s cnt%0d_b", tag, i), 32'(counts_b[i*2 +: 2]), satv(tally[i], 3));
    end
    checkOutput({tag, " nulo_a"}, 32'(nulo_a), satv(tally[NC], 255));
    checkOutput({tag, " nulo_b"}, 32'(nulo_b), satv(tally[NC], 3));
    checkOutput({tag, " branco_a"}, 32'(branco_a), satv(tally[NC+1], 255));
    checkOutput({tag, " branco_b"}, 32'(branco_b), satv(tally[NC+1], 3));
    checkOutput({tag, " ndig_a"}, 32'(ndig_a), entered.size());
    checkOutput({tag, " ndig_b"}, 32'(ndig_b), entered.size());
    checkOutput({tag, " ovf_a"}, 32'(overflow_a), 32'(anyOver(255)));
    checkOutput({tag, " ovf_b"}, 32'(overflow_b), 32'(anyOver(3)));
  endtask

  // kind: 0 digit, 1 finish, 2 cancel, 3 cancel+finish+valid, 4 finish+valid.
  // Called on a falling edge; returns on a falling edge with inputs low.
  task automatic applyStimulus(input int kind, input logic [3:0] d);
    bit exp_err = 1'b0;
    bit exp_vd  = 1'b0;
    if (!locked) begin
      case (kind)
        0: if (entered.size() < ND) begin
             if (d > 9) exp_err = 1'b1;
             else entered.push_back(d);
           end
        1, 4: begin
          exp_vd = 1'b1;
          tally[voteIndex()]++;
          entered.delete();
        end
        default: entered.delete();
      endcase
    end
    digit  = d;
    valid  = (kind == 0 || kind == 3 || kind == 4);
    finish = (kind == 1 || kind == 3 || kind == 4);
    cancel = (kind == 2 || kind == 3);
    @(negedge clock);
    checkOutput($sformatf("err k%0d", kind), 32'(err_a), 32'(exp_err));
    checkOutput($sformatf("err_b k%0d", kind), 32'(err_b), 32'(exp_err));
    checkOutput($sformatf("vote_done k%0d", kind), 32'(vote_done_a), 32'(exp_vd));
    checkOutput($sformatf("status k%0d", kind), 32'(status_a), 32'(!(exp_vd || locked)));
    valid  = 1'b0;
    finish = 1'b0;
    cancel = 1'b0;
    repeat (2) @(negedge clock);
    checkTallies($sformatf("after k%0d", kind));
  endtask

  task automatic enterCode(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) applyStimulus(0, code[i*4 +: 4]);
  endtask

  task automatic closeSequence();
    close = 1'b1;
    locked = 1'b1;
    entered.delete();
    @(negedge clock);
    checkOutput("closed status", 32'(status_a), 0);
    checkOutput("closed ndig", 32'(ndig_a), 0);
    applyStimulus(0, 4'd3);
    applyStimulus(1, 4'd0);
    close = 1'b0;
    locked = 1'b0;
    @(negedge clock);
    checkOutput("reopened status", 32'(status_a), 1);
    checkOutput("reopened status_b", 32'(status_b), 1);
  endtask

  initial begin
    int r;
    reset_n = 1'b0;
    digit = '0; valid = 1'b0; finish = 1'b0; cancel = 1'b0; close = 1'b0;
    foreach (tally[i]) tally[i] = 0;
    repeat (2) @(negedge clock);
    checkOutput("reset status", 32'(status_a), 1);
    checkOutput("reset vote_done", 32'(vote_done_a), 0);
    checkOutput("reset err", 32'(err_a), 0);
    reset_n = 1'b1;
    @(negedge clock);
    checkTallies("reset");

    // Directed votes for each candidate, null, blank and correction cases.
    enterCode(16'h3494); applyStimulus(1, 4'd0);
    enterCode(16'h3485); applyStimulus(1, 4'd0);
    enterCode(16'h3472); applyStimulus(1, 4'd0);
    enterCode(16'h3504); applyStimulus(1, 4'd0);
    applyStimulus(0, 4'd3); applyStimulus(0, 4'd0); applyStimulus(1, 4'd0);
    applyStimulus(1, 4'd0);
    enterCode(16'h1111); applyStimulus(1, 4'd0);
    applyStimulus(0, 4'd3); applyStimulus(0, 4'd4); applyStimulus(2, 4'd0);
    enterCode(16'h3494); applyStimulus(1, 4'd0);
    applyStimulus(0, 4'hC);
    enterCode(16'h3494); applyStimulus(0, 4'd5); applyStimulus(1, 4'd0);
    enterCode(16'h3494); applyStimulus(1, 4'd0);
    checkOutput("cand0 saturated b", 32'(counts_b[1:0]), 3);
    checkOutput("overflow_b set", 32'(overflow_b), 1);

    // Close mid-entry, then a combined-event priority check.
    applyStimulus(0, 4'd3);
    closeSequence();
    applyStimulus(0, 4'd3); applyStimulus(3, 4'd4);
    enterCode(16'h3485); applyStimulus(4, 4'd7);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       applyStimulus(0, 4'($urandom_range(10, 15)));
      else if (r < 45) applyStimulus(0, 4'($urandom_range(0, 9)));
      else if (r < 55) enterCode(cand_code[$urandom_range(0, NC-1)]);
      else if (r < 75) applyStimulus(1, 4'd0);
      else if (r < 85) applyStimulus(2, 4'd0);
      else if (r < 90) applyStimulus(3, 4'($urandom_range(0, 9)));
      else if (r < 95) applyStimulus(4, 4'($urandom_range(0, 9)));
      else             closeSequence();
    end

    // Reset in the middle of a COMMIT wipes everything at once.
    applyStimulus(2, 4'd0);
    enterCode(16'h3494);
    finish = 1'b1;
    @(negedge clock);
    checkOutput("commit vote_done", 32'(vote_done_a), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async counts_a", 32'(counts_a), 0);
    checkOutput("async counts_b", 32'(counts_b), 0);
    checkOutput("async nulo_a", 32'(nulo_a), 0);
    checkOutput("async branco_a", 32'(branco_a), 0);
    checkOutput("async vote_done", 32'(vote_done_a), 0);
    checkOutput("async overflow_b", 32'(overflow_b), 0);
    finish = 1'b0;
    foreach (tally[i]) tally[i] = 0;
    entered.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkTallies("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
